prog_sequencer: RTL and testbench
=================================

PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter START_CYCLES, default 2, number of cycles DutStart is held high per program (legal 1..15).
REQ-002 Parameter TIMEOUT_CYCLES, default 16'd4000, maximum RUN cycles allowed per program before abort.
REQ-003 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Go  input  1  level; sampled in IDLE or DONE to launch a sequence.
REQ-006 NumProgs  input  2  program count minus one (0 means 1 program, 3 means 4); latched when Go is accepted.
REQ-007 Ack  input  1  done flag from processor core.
REQ-008 DutReset  output  1  reset to processor core.
REQ-009 DutStart  output  1  start to processor core; core idles while high and runs after it falls.
REQ-010 ProgIdx  output  2  index of program currently launched or running.
REQ-011 Busy  output  1  high in RST, START and RUN.
REQ-012 Done  output  1  high in DONE.
REQ-013 ProgDone  output  1  one-cycle pulse when a program's Ack is accepted.
REQ-014 LastCycles  output  16  RUN-cycle count of the most recently completed program.
REQ-015 Timeout  output  1  sticky abort flag for the current sequence.

Function
REQ-016 FSM states SHALL be IDLE, RST, START, RUN, DONE.
REQ-017 IDLE: all outputs 0; Go=1 -> RST, latch NumProgs, clear Timeout, ProgIdx=0.
REQ-018 RST: DutReset=1 for exactly one cycle, DutStart=0 -> START.
REQ-019 START: DutStart=1 for exactly START_CYCLES cycles (4-bit down-counter), then -> RUN; Ack ignored in START.
REQ-020 RUN: DutStart=0; 16-bit run counter starts at 1 in the first RUN cycle and increments each cycle.
REQ-021 RUN with Ack=1: LastCycles <= run counter value that cycle, ProgDone pulses next cycle; if ProgIdx == latched count -> DONE, else ProgIdx+1 and -> START (no DutReset between programs).
REQ-022 RUN without Ack when run counter == TIMEOUT_CYCLES: Timeout <= 1, LastCycles unchanged -> DONE.
REQ-023 DONE: Done=1, Busy=0, ProgIdx, LastCycles and Timeout hold; Go=1 -> RST (new sequence); Go=0 stays.
REQ-024 Go while Busy SHALL be ignored; NumProgs changes while Busy SHALL have no effect.
REQ-025 Ack in IDLE, RST, START or DONE SHALL be ignored and SHALL not alter any output.
REQ-026 Ack and timeout in the same RUN cycle: Ack wins; Timeout stays 0.
REQ-027 Run counter SHALL saturate at 16'hFFFF, never wrap.
REQ-028 ProgIdx wrap is impossible: maximum value 3 equals maximum latched count.

Reset
REQ-029 Reset=1 at any posedge SHALL force IDLE, DutReset=0, DutStart=0, ProgIdx=0, Busy=0, Done=0, ProgDone=0, LastCycles=0, Timeout=0, all counters 0.
REQ-030 Reset mid-sequence SHALL abort immediately; no ProgDone pulse and no LastCycles update in that cycle.
REQ-031 Reset dominates Go and Ack in the same cycle.

Configuration
REQ-032 Macro PROG_SEQ_TIMEOUT_EN: when defined, REQ-022 watchdog is compiled in; when undefined, no comparator exists, Timeout is tied 0, RUN waits for Ack indefinitely, and TIMEOUT_CYCLES is unused.

Verification
REQ-033 Reset, Go=1, NumProgs=0, Ack at 5th RUN cycle -> DutReset 1 cycle, DutStart 2 cycles, LastCycles=5, ProgDone one pulse, Done=1, Timeout=0.
REQ-034 NumProgs=2, Ack after 3, 7, 1 RUN cycles -> three START phases, ProgIdx 0,1,2, LastCycles final 1, exactly three ProgDone pulses, one DutReset total.
REQ-035 With PROG_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=10, no Ack -> Timeout=1 after 10th RUN cycle, Done=1, LastCycles=0; Ack on 10th cycle instead -> LastCycles=10, Timeout=0.
REQ-036 Ack held high during START and Go toggled during RUN -> no ProgDone until RUN, no relaunch, ProgIdx unchanged.
REQ-037 Reset asserted in 3rd RUN cycle of program 1 -> next cycle all outputs at reset values; subsequent Go starts at ProgIdx=0.

Source files
------------

// File: rtl/prog_sequencer.sv
// Program sequencer: resets a processor core once, then launches and times up to four programs in turn.
// Optional run watchdog is compiled in when PROG_SEQ_TIMEOUT_EN is defined.
module prog_sequencer #(
  parameter int unsigned START_CYCLES   = 2,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Go,
  input  logic [1:0]  NumProgs,
  input  logic        Ack,
  output logic        DutReset,
  output logic        DutStart,
  output logic [1:0]  ProgIdx,
  output logic        Busy,
  output logic        Done,
  output logic        ProgDone,
  output logic [15:0] LastCycles,
  output logic        Timeout
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RST   = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [3:0] START_LOAD = 4'(START_CYCLES);

  logic [2:0]  state;
  logic [2:0]  stateNext;
  logic [1:0]  numLatched;
  logic [3:0]  startCnt;
  logic [15:0] runCnt;
  logic        lastProg;
  logic        runExpired;

  assign lastProg = (ProgIdx == numLatched);

`ifdef PROG_SEQ_TIMEOUT_EN
  assign runExpired = (runCnt == TIMEOUT_CYCLES);
`else
  logic unusedTimeoutCycles;
  assign unusedTimeoutCycles = ^TIMEOUT_CYCLES;
  assign runExpired = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    case (state)
      IDLE, DONE: if (Go) stateNext = RST;
      RST:        stateNext = START;
      START:      if (startCnt == 4'd1) stateNext = RUN;
      RUN: begin
        // Ack takes priority over an expiring watchdog in the same cycle
        if (Ack)             stateNext = lastProg ? DONE : START;
        else if (runExpired) stateNext = DONE;
      end
      default:    stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      numLatched <= '0;
      startCnt   <= '0;
      runCnt     <= '0;
      ProgIdx    <= '0;
      ProgDone   <= 1'b0;
      LastCycles <= '0;
      Timeout    <= 1'b0;
    end else begin
      state    <= stateNext;
      ProgDone <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (Go) begin
            numLatched <= NumProgs;
            Timeout    <= 1'b0;
            ProgIdx    <= '0;
          end
        end
        RST: startCnt <= START_LOAD;
        START: begin
          startCnt <= startCnt - 4'd1;
          if (startCnt == 4'd1) runCnt <= 16'd1;
        end
        RUN: begin
          if (Ack) begin
            LastCycles <= runCnt;
            ProgDone   <= 1'b1;
            if (!lastProg) begin
              ProgIdx  <= ProgIdx + 2'd1;
              startCnt <= START_LOAD;
            end
          end else if (runExpired) begin
            Timeout <= 1'b1;
          end else if (runCnt != '1) begin
            runCnt <= runCnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign DutReset = (state == RST);
  assign DutStart = (state == START);
  assign Busy     = (state == RST) || (state == START) || (state == RUN);
  assign Done     = (state == DONE);

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed self-checking bench for prog_sequencer (START_CYCLES=2, TIMEOUT_CYCLES=10).
module tb_prog_sequencer;

  logic        Clk = 1'b0;
  logic        Reset, Go, Ack;
  logic [1:0]  NumProgs;
  logic        DutReset, DutStart, Busy, Done, ProgDone, Timeout;
  logic [1:0]  ProgIdx;
  logic [15:0] LastCycles;

  int total = 0;
  int bad   = 0;
  int cntDutReset, cntDutStart, cntProgDone;

  prog_sequencer #(.START_CYCLES(2), .TIMEOUT_CYCLES(16'd10)) dut (
    .Clk(Clk), .Reset(Reset), .Go(Go), .NumProgs(NumProgs), .Ack(Ack),
    .DutReset(DutReset), .DutStart(DutStart), .ProgIdx(ProgIdx), .Busy(Busy),
    .Done(Done), .ProgDone(ProgDone), .LastCycles(LastCycles), .Timeout(Timeout)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (DutReset) cntDutReset = cntDutReset + 1;
    if (DutStart) cntDutStart = cntDutStart + 1;
    if (ProgDone) cntProgDone = cntProgDone + 1;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clearCounts();
    cntDutReset = 0;
    cntDutStart = 0;
    cntProgDone = 0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Go = 1'b0; Ack = 1'b0; NumProgs = 2'd0;
    tick(); tick();
    total++;
    if ({DutReset, DutStart, Busy, Done, ProgDone, Timeout, ProgIdx, LastCycles} !== 24'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %0h want 0",
               {DutReset, DutStart, Busy, Done, ProgDone, Timeout, ProgIdx, LastCycles});
    end
    Reset = 1'b0;
    tick();
    total++;
    if ({Busy, Done} !== 2'b00) begin
      bad++; $display("FAIL idle_hold: busy/done got %b want 00", {Busy, Done});
    end
  endtask

  task automatic test_single();
    clearCounts();
    Go = 1'b1; NumProgs = 2'd0;
    tick(); Go = 1'b0;
    total++;
    if ({DutReset, DutStart, Busy} !== 3'b101) begin
      bad++; $display("FAIL single_rst: got %b want 101", {DutReset, DutStart, Busy});
    end
    tick(); tick();
    tick();
    total++;
    if ({DutStart, Busy} !== 2'b01) begin
      bad++; $display("FAIL single_run_entry: got %b want 01", {DutStart, Busy});
    end
    for (int k = 2; k <= 5; k++) tick();
    Ack = 1'b1;
    tick(); Ack = 1'b0;
    total++;
    if ({Done, Busy, ProgDone, Timeout} !== 4'b1010 || LastCycles !== 16'd5) begin
      bad++;
      $display("FAIL single_done: flags got %b want 1010, last got %0d want 5",
               {Done, Busy, ProgDone, Timeout}, LastCycles);
    end
    tick();
    total++;
    if (cntDutReset !== 1 || cntDutStart !== 2 || cntProgDone !== 1 || ProgDone !== 1'b0 || Done !== 1'b1) begin
      bad++;
      $display("FAIL single_counts: rst=%0d start=%0d pd=%0d pdnow=%b done=%b want 1 2 1 0 1",
               cntDutReset, cntDutStart, cntProgDone, ProgDone, Done);
    end
  endtask

  task automatic test_multi();
    int runLen [3] = '{3, 7, 1};
    clearCounts();
    Go = 1'b1; NumProgs = 2'd2;
    tick(); Go = 1'b0; NumProgs = 2'd0;
    tick();
    for (int p = 0; p < 3; p++) begin
      total++;
      if (DutStart !== 1'b1 || ProgIdx !== 2'(p)) begin
        bad++; $display("FAIL multi_start p%0d: start=%b idx=%0d want 1 %0d", p, DutStart, ProgIdx, p);
      end
      tick();
      for (int k = 1; k <= runLen[p]; k++) tick();
      Ack = 1'b1;
      tick(); Ack = 1'b0;
      total++;
      if (LastCycles !== 16'(runLen[p]) || ProgDone !== 1'b1) begin
        bad++;
        $display("FAIL multi_ack p%0d: last=%0d pd=%b want %0d 1", p, LastCycles, ProgDone, runLen[p]);
      end
    end
    total++;
    if (Done !== 1'b1 || ProgIdx !== 2'd2) begin
      bad++; $display("FAIL multi_done: done=%b idx=%0d want 1 2", Done, ProgIdx);
    end
    tick();
    total++;
    if (cntDutReset !== 1 || cntDutStart !== 6 || cntProgDone !== 3 || LastCycles !== 16'd1) begin
      bad++;
      $display("FAIL multi_counts: rst=%0d start=%0d pd=%0d last=%0d want 1 6 3 1",
               cntDutReset, cntDutStart, cntProgDone, LastCycles);
    end
  endtask

  task automatic test_ack_go_ignored();
    clearCounts();
    Go = 1'b1; NumProgs = 2'd0;
    tick(); Go = 1'b0; Ack = 1'b1;
    tick(); tick(); tick();
    Ack = 1'b0;
    total++;
    if (cntProgDone !== 0 || ProgDone !== 1'b0 || Busy !== 1'b1 || DutStart !== 1'b0) begin
      bad++;
      $display("FAIL start_ack_ignored: pd=%0d busy=%b start=%b want 0 1 0", cntProgDone, Busy, DutStart);
    end
    Go = 1'b1; tick(); Go = 1'b0; tick(); Go = 1'b1; tick(); Go = 1'b0;
    total++;
    if (Busy !== 1'b1 || DutReset !== 1'b0 || ProgIdx !== 2'd0 || cntDutReset !== 1 || ProgDone !== 1'b0) begin
      bad++;
      $display("FAIL run_go_ignored: busy=%b rst=%b idx=%0d nrst=%0d pd=%b want 1 0 0 1 0",
               Busy, DutReset, ProgIdx, cntDutReset, ProgDone);
    end
    Ack = 1'b1;
    tick(); Ack = 1'b0;
    total++;
    if (LastCycles !== 16'd4 || Done !== 1'b1) begin
      bad++; $display("FAIL run_go_last: last=%0d done=%b want 4 1", LastCycles, Done);
    end
    tick();
    Ack = 1'b1; tick(); tick(); Ack = 1'b0;
    total++;
    if (LastCycles !== 16'd4 || ProgDone !== 1'b0 || Done !== 1'b1 || Busy !== 1'b0) begin
      bad++;
      $display("FAIL done_ack_ignored: last=%0d pd=%b done=%b busy=%b want 4 0 1 0",
               LastCycles, ProgDone, Done, Busy);
    end
  endtask

  task automatic test_timeout();
    Reset = 1'b1; tick(); Reset = 1'b0;
    Go = 1'b1; NumProgs = 2'd0;
    tick(); Go = 1'b0;
    tick(); tick();
`ifdef PROG_SEQ_TIMEOUT_EN
    for (int k = 1; k <= 10; k++) tick();
    total++;
    if (Busy !== 1'b1 || Timeout !== 1'b0) begin
      bad++; $display("FAIL timeout_run10: busy=%b to=%b want 1 0", Busy, Timeout);
    end
    tick();
    total++;
    if (Timeout !== 1'b1 || Done !== 1'b1 || LastCycles !== 16'd0 || ProgDone !== 1'b0) begin
      bad++;
      $display("FAIL timeout_abort: to=%b done=%b last=%0d pd=%b want 1 1 0 0", Timeout, Done, LastCycles, ProgDone);
    end
    Go = 1'b1; tick(); Go = 1'b0;
    total++;
    if (Timeout !== 1'b0) begin
      bad++; $display("FAIL timeout_clear: to=%b want 0", Timeout);
    end
    tick(); tick();
    for (int k = 1; k <= 10; k++) tick();
    Ack = 1'b1; tick(); Ack = 1'b0;
    total++;
    if (Timeout !== 1'b0 || LastCycles !== 16'd10 || Done !== 1'b1) begin
      bad++;
      $display("FAIL timeout_ack_wins: to=%b last=%0d done=%b want 0 10 1", Timeout, LastCycles, Done);
    end
`else
    for (int k = 1; k <= 30; k++) tick();
    total++;
    if (Busy !== 1'b1 || Timeout !== 1'b0 || Done !== 1'b0) begin
      bad++; $display("FAIL no_watchdog: busy=%b to=%b done=%b want 1 0 0", Busy, Timeout, Done);
    end
    Ack = 1'b1; tick(); Ack = 1'b0;
    total++;
    if (LastCycles !== 16'd30 || Done !== 1'b1 || Timeout !== 1'b0) begin
      bad++;
      $display("FAIL no_watchdog_ack: last=%0d done=%b to=%b want 30 1 0", LastCycles, Done, Timeout);
    end
`endif
  endtask

  task automatic test_reset_mid();
    Reset = 1'b1; tick(); Reset = 1'b0;
    Go = 1'b1; NumProgs = 2'd1;
    tick(); Go = 1'b0;
    tick(); tick();
    tick(); tick();
    Ack = 1'b1; tick(); Ack = 1'b0;
    tick();
    tick(); tick(); tick();
    total++;
    if (ProgIdx !== 2'd1 || Busy !== 1'b1 || LastCycles !== 16'd2) begin
      bad++; $display("FAIL mid_setup: idx=%0d busy=%b last=%0d want 1 1 2", ProgIdx, Busy, LastCycles);
    end
    Reset = 1'b1; Ack = 1'b1; Go = 1'b1;
    tick();
    Reset = 1'b0; Ack = 1'b0; Go = 1'b0;
    total++;
    if ({DutReset, DutStart, Busy, Done, ProgDone, Timeout, ProgIdx, LastCycles} !== 24'd0) begin
      bad++;
      $display("FAIL mid_reset: got %0h want 0",
               {DutReset, DutStart, Busy, Done, ProgDone, Timeout, ProgIdx, LastCycles});
    end
    tick();
    Go = 1'b1; NumProgs = 2'd0;
    tick(); Go = 1'b0;
    total++;
    if (ProgIdx !== 2'd0 || DutReset !== 1'b1) begin
      bad++; $display("FAIL mid_relaunch: idx=%0d rst=%b want 0 1", ProgIdx, DutReset);
    end
    tick(); tick(); tick();
    Ack = 1'b1; tick(); Ack = 1'b0;
    total++;
    if (LastCycles !== 16'd1 || Done !== 1'b1) begin
      bad++; $display("FAIL mid_final: last=%0d done=%b want 1 1", LastCycles, Done);
    end
  endtask

  initial begin
    clearCounts();
    test_reset();
    test_single();
    test_multi();
    test_ack_go_ignored();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
